// File: rtl/conv_window.sv
// ---------------------------------------------------------------------------
// conv_pkg / conv_window
//
// Builds a 5x5 pixel neighbourhood around every centre pixel of a frame.
// The upstream line-buffer controller supplies one 5-row column per pixel.
// Each column comes with the kernel position flags of its centre-row pixel.
// Rows that fall outside the frame are clamped when the column is accepted.
// Columns outside the frame are clamped on the window output.
// Finished windows go through a 2-entry skid FIFO to a valid/ready master port.
// After the last pixel of a frame, two internal flush shifts emit the windows
// for the final two centre columns. No further input column is needed.
//
// Ports
//   clk, arst_n   clock, asynchronous active-low reset
//   col_vld_i     column valid
//   col_pos_i     kernel_pos_t flags of the pushed column's centre-row pixel
//   col_data_i    5 rows, index 0 = row -2 (north), PIXEL_W bits each
//   col_ready_o   column accepted when col_vld_i & col_ready_o
//   m_tvalid_o    window valid (skid FIFO not empty)
//   m_tready_i    downstream ready
//   m_tdata_o     window[r][c] at element r*5+c, element 0 in the LSBs
//   m_tuser_o     start of frame (centre at row 0, column 0)
//   m_tlast_o     end of line (centre in the last column)
// ---------------------------------------------------------------------------
package conv_pkg;

  localparam int PIXEL_W = 8;

  // Edge flags of one pixel. x2 means the pixel lies on that border.
  // x1 means the pixel is one pixel in from that border.
  typedef struct packed {
    logic w2;
    logic w1;
    logic e2;
    logic e1;
    logic n2;
    logic n1;
    logic s2;
    logic s1;
  } kernel_pos_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH1,
    ST_FLUSH2
  } state_t;

endpackage

module conv_window #(
  parameter int PIXEL_W = conv_pkg::PIXEL_W,
  parameter int MIN_DIM = 5
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   col_vld_i,
  input  logic [7:0]             col_pos_i,
  input  logic [5*PIXEL_W-1:0]   col_data_i,
  output logic                   col_ready_o,
  output logic                   m_tvalid_o,
  input  logic                   m_tready_i,
  output logic [25*PIXEL_W-1:0]  m_tdata_o,
  output logic                   m_tuser_o,
  output logic                   m_tlast_o
);

  // The kernel edge equals the smallest supported frame dimension.
  // The two-deep border clamps are only correct when the frame is at least
  // as large as the window.
  localparam int K = MIN_DIM;

  typedef logic [K-1:0][PIXEL_W-1:0]        col_t;  // [row]
  typedef logic [K-1:0][K-1:0][PIXEL_W-1:0] win_t;  // [slot][row]

  typedef struct packed {
    logic [K*K*PIXEL_W-1:0] data;
    logic                   user;
    logic                   last;
  } beat_t;

  conv_pkg::state_t      state;
  conv_pkg::kernel_pos_t pos_in;
  conv_pkg::kernel_pos_t centre;
  // Positions of the columns in slots 4 and 3. A slot's position matters only
  // when that slot becomes the centre, which happens during the shift.
  // So the slot-3 entry supplies the centre directly, and slot 2 needs no
  // storage of its own.
  conv_pkg::kernel_pos_t pos_q [2];

  col_t  col_in;
  col_t  col_clamped;
  win_t  win_q;
  win_t  win_shift;
  win_t  win_out;
  beat_t beat_in;
  beat_t fifo_mem [2];
  beat_t head;

  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] fifo_cnt;
  logic [1:0] fill_cnt;

  logic room;
  logic accepting;
  logic flushing;
  logic accept;
  logic flush_shift;
  logic shift;
  logic sof_in;
  logic eof_in;
  logic gen;
  logic pop;

  assign pos_in = conv_pkg::kernel_pos_t'(col_pos_i);
  assign col_in = col_t'(col_data_i);
  assign sof_in = pos_in.n2 & pos_in.w2;
  assign eof_in = pos_in.s2 & pos_in.e2;

  // A new window fits if the skid has a free entry. It also fits if the head
  // leaves on this same edge.
  assign pop       = m_tvalid_o & m_tready_i;
  assign room      = (fifo_cnt != 2'd2) | m_tready_i;
  assign accepting = (state == conv_pkg::ST_IDLE) | (state == conv_pkg::ST_RUN);
  assign flushing  = (state == conv_pkg::ST_FLUSH1) | (state == conv_pkg::ST_FLUSH2);

  // col_ready_o is held low while reset is asserted, so nothing is accepted
  // during reset and every output reads 0.
  assign col_ready_o = arst_n & accepting & room;
  assign accept      = col_vld_i & col_ready_o;
  assign flush_shift = flushing & room;
  assign shift       = accept | flush_shift;

  // A frame-start column restarts the fill count, so it never completes a
  // window. The same holds in IDLE: columns there only prime the window.
  assign gen = shift & (fill_cnt == 2'd2) & (state != conv_pkg::ST_IDLE) &
               ~(accept & sof_in);

  // Row clamp on the incoming column.
  always_comb begin
    // NOTE: assign every always_comb output a default first. A path that skips
    // an assignment would otherwise infer a latch.
    col_clamped = col_in;
    if (pos_in.n2) begin
      col_clamped[0] = col_in[2];
      col_clamped[1] = col_in[2];
    end else if (pos_in.n1) begin
      col_clamped[0] = col_in[1];
    end
    if (pos_in.s2) begin
      col_clamped[3] = col_in[2];
      col_clamped[4] = col_in[2];
    end else if (pos_in.s1) begin
      col_clamped[4] = col_in[3];
    end
  end

  // The window as it will look after this shift. The new column enters
  // slot 4. During flush, slot 4 is filler that the east clamp always hides.
  always_comb begin
    win_shift = win_q;
    for (int s = 0; s < K-1; s++) win_shift[s] = win_q[s+1];
    win_shift[K-1] = flushing ? col_t'('0) : col_clamped;
  end

  assign centre = pos_q[1];

  // Column clamp on the shifted window. Its rows are already clamped, so
  // corner pixels replicate correctly.
  always_comb begin
    win_out = win_shift;
    if (centre.w2) begin
      win_out[0] = win_shift[2];
      win_out[1] = win_shift[2];
    end else if (centre.w1) begin
      win_out[0] = win_shift[1];
    end
    if (centre.e2) begin
      win_out[3] = win_shift[2];
      win_out[4] = win_shift[2];
    end else if (centre.e1) begin
      win_out[4] = win_shift[3];
    end
  end

  // Row-major flattening: the storage is slot-major, the output is [r][c].
  always_comb begin
    beat_in = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        beat_in.data[(r*K+c)*PIXEL_W +: PIXEL_W] = win_out[c][r];
      end
    end
    beat_in.user = centre.n2 & centre.w2;
    beat_in.last = centre.e2;
  end

  // Window and position shift registers.
  always_ff @(posedge clk or negedge arst_n) begin
    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then update together from pre-edge values.
    if (!arst_n) begin
      win_q    <= '0;
      pos_q[0] <= '0;
      pos_q[1] <= '0;
    end else if (shift) begin
      win_q    <= win_shift;
      pos_q[1] <= pos_q[0];
      pos_q[0] <= flushing ? conv_pkg::kernel_pos_t'('0) : pos_in;
    end
  end

  // Frame sequencing and fill count.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= conv_pkg::ST_IDLE;
      fill_cnt <= 2'd0;
    end else begin
      if (accept && sof_in) begin
        fill_cnt <= 2'd1;
      end else if (shift && fill_cnt != 2'd2) begin
        fill_cnt <= fill_cnt + 2'd1;
      end

      case (state)
        conv_pkg::ST_IDLE:   if (accept && sof_in) state <= conv_pkg::ST_RUN;
        conv_pkg::ST_RUN:    if (accept && eof_in) state <= conv_pkg::ST_FLUSH1;
        conv_pkg::ST_FLUSH1: if (flush_shift)      state <= conv_pkg::ST_FLUSH2;
        conv_pkg::ST_FLUSH2: if (flush_shift)      state <= conv_pkg::ST_IDLE;
        default:                                   state <= conv_pkg::ST_IDLE;
      endcase
    end
  end

  // Two-entry skid FIFO. A push and a pop on the same edge keep the count
  // unchanged, even when the FIFO is full.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      // NOTE: the two skid entries are reset as well. The head entry drives
      // the outputs directly, and every output must read 0 while in reset.
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (gen) begin
        fifo_mem[wr_ptr] <= beat_in;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, gen} - {1'b0, pop};
    end
  end

  assign head       = fifo_mem[rd_ptr];
  assign m_tvalid_o = (fifo_cnt != 2'd0);
  assign m_tdata_o  = head.data;
  assign m_tuser_o  = head.user;
  assign m_tlast_o  = head.last;

endmodule

// File: tb/tb_conv_window.sv
// ---------------------------------------------------------------------------
// tb_conv_window
//
// Self-checking bench for conv_window.
// For every pixel of a frame, the reference model builds the expected 5x5
// window directly from the whole frame image. It uses clamped row/column
// arithmetic to do so. A scoreboard compares each popped window in order.
// The bench also runs a table of frame scenarios plus hand-written sequences:
// a downstream stall, the end-of-frame flush feeding a back-to-back frame,
// and a reset mid-frame.
// ---------------------------------------------------------------------------
module tb_conv_window;

  localparam int PW = conv_pkg::PIXEL_W;
  localparam int DW = 25 * PW;

  logic            clk = 1'b0;
  logic            arst_n;
  logic            col_vld;
  logic [7:0]      col_pos;
  logic [5*PW-1:0] col_data;
  logic            col_ready;
  logic            m_tvalid;
  logic            m_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tuser;
  logic            m_tlast;

  always #5 clk = ~clk;

  conv_window dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .col_vld_i   (col_vld),
    .col_pos_i   (col_pos),
    .col_data_i  (col_data),
    .col_ready_o (col_ready),
    .m_tvalid_o  (m_tvalid),
    .m_tready_i  (m_tready),
    .m_tdata_o   (m_tdata),
    .m_tuser_o   (m_tuser),
    .m_tlast_o   (m_tlast)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          user;
    logic          last;
  } exp_t;

  typedef struct {
    int h;
    int w;
    bit pat;      // 1: pixel = r*w+c, 0: random pixels
    int rmode;    // 0: tready high, 1: toggling, 2: random
    int gap;      // percent chance of an idle gap before a column
    int exp_n;    // windows the frame must produce
  } vec_t;

  exp_t          exp_q[$];
  logic [PW-1:0] img [16][16];
  int            total = 0;
  int            bad = 0;
  int            win_cnt = 0;
  int            ready_mode = 0;
  bit            stall = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] got,
                       input logic [DW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic build_img(input int h, input int w, input bit pat);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        img[r][c] = pat ? PW'(r*w + c) : PW'($urandom);
  endtask

  // Reference model. Window element [r][c] is the image pixel at the clamped
  // offset (r-2, c-2) from the centre.
  task automatic push_expect(input int h, input int w);
    exp_t e;
    for (int pr = 0; pr < h; pr++) begin
      for (int pc = 0; pc < w; pc++) begin
        e.data = '0;
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++)
            e.data[(r*5+c)*PW +: PW] =
              img[clampi(pr+r-2, h-1)][clampi(pc+c-2, w-1)];
        e.user = (pr == 0) && (pc == 0);
        e.last = (pc == w-1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Drive the column for pixel (pr, pc). Rows outside the frame carry
  // garbage, which the row clamp must hide.
  task automatic drive_col(input int pr, input int pc, input int h, input int w);
    logic [5*PW-1:0] d;
    for (int k = 0; k < 5; k++) begin
      int row = pr + k - 2;
      d[k*PW +: PW] = (row >= 0 && row < h) ? img[row][pc] : PW'($urandom);
    end
    col_pos  = {pc == 0, pc == 1, pc == w-1, pc == w-2,
                pr == 0, pr == 1, pr == h-1, pr == h-2};
    col_data = d;
    col_vld  = 1'b1;
  endtask

  task automatic send_col(input int pr, input int pc, input int h, input int w,
                          input int gap);
    int n = 0;
    if (gap > 0 && $urandom_range(0, 99) < gap)
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    drive_col(pr, pc, h, w);
    forever begin
      @(negedge clk);
      if (col_ready) break;
      n++;
      if (n > 1000) begin
        total++;
        bad++;
        $display("FAIL col_accept_timeout got=0 want=1");
        break;
      end
    end
    @(posedge clk);
    #1;
    col_vld = 1'b0;
  endtask

  task automatic send_frame(input int h, input int w, input bit pat, input int gap);
    build_img(h, w, pat);
    push_expect(h, w);
    for (int pr = 0; pr < h; pr++)
      for (int pc = 0; pc < w; pc++)
        send_col(pr, pc, h, w, gap);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Downstream ready pattern.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall) m_tready = 1'b0;
      else begin
        case (ready_mode)
          0:       m_tready = 1'b1;
          1:       m_tready = ~m_tready;
          default: m_tready = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  // Scoreboard. A window sampled at the negedge with valid & ready is popped
  // on the next posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (arst_n && m_tvalid && m_tready) begin
        win_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_window got=%0h want=none", m_tdata);
        end else begin
          e = exp_q.pop_front();
          check("win_data", m_tdata, e.data);
          check("win_user", m_tuser, e.user);
          check("win_last", m_tlast, e.last);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   n0;

    vecs[0] = '{h: 5, w: 5, pat: 1'b1, rmode: 0, gap: 0,  exp_n: 25};
    vecs[1] = '{h: 5, w: 6, pat: 1'b1, rmode: 0, gap: 0,  exp_n: 30};
    vecs[2] = '{h: 6, w: 7, pat: 1'b0, rmode: 1, gap: 0,  exp_n: 42};
    vecs[3] = '{h: 7, w: 5, pat: 1'b0, rmode: 2, gap: 30, exp_n: 35};
    vecs[4] = '{h: 5, w: 8, pat: 1'b0, rmode: 1, gap: 0,  exp_n: 40};

    arst_n   = 1'b0;
    col_vld  = 1'b0;
    col_pos  = '0;
    col_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tuser", m_tuser, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_col_ready", col_ready, 0);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_col_ready", col_ready, 1);

    // Table of frame scenarios.
    foreach (vecs[i]) begin
      ready_mode = vecs[i].rmode;
      n0 = win_cnt;
      send_frame(vecs[i].h, vecs[i].w, vecs[i].pat, vecs[i].gap);
      drain("frame_drain");
      check("frame_windows", win_cnt - n0, vecs[i].exp_n);
    end

    // Downstream stall for 10 cycles mid-line.
    ready_mode = 0;
    n0 = win_cnt;
    fork
      send_frame(5, 5, 1'b0, 0);
      begin
        repeat (12) @(posedge clk);
        #1;
        stall = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall_col_ready", col_ready, 0);
        check("stall_tvalid", m_tvalid, 1);
        @(posedge clk);
        #1;
        stall = 1'b0;
      end
    join
    drain("stall_drain");
    check("stall_windows", win_cnt - n0, 25);

    // End-of-frame flush, then a back-to-back second frame.
    n0 = win_cnt;
    send_frame(5, 5, 1'b0, 0);
    fork
      send_frame(5, 6, 1'b0, 0);
      begin
        @(negedge clk);
        check("flush1_col_ready", col_ready, 0);
        @(negedge clk);
        check("flush2_col_ready", col_ready, 0);
        @(negedge clk);
        check("after_flush_accept", col_ready & col_vld, 1);
      end
    join
    drain("b2b_drain");
    check("b2b_windows", win_cnt - n0, 55);

    // Reset mid-frame with both skid entries occupied.
    stall = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    build_img(5, 5, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive_col(i / 5, i % 5, 5, 5);
      @(negedge clk);
      if (!col_ready) break;
      @(posedge clk);
      #1;
    end
    check("pre_rst_tvalid", m_tvalid, 1);
    check("pre_rst_col_ready", col_ready, 0);
    col_vld = 1'b0;
    #1;
    arst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", m_tvalid, 0);
    check("mid_rst_tdata", m_tdata, 0);
    @(negedge clk);
    arst_n = 1'b1;
    stall  = 1'b0;
    @(posedge clk);
    #1;
    n0 = win_cnt;
    send_frame(5, 5, 1'b1, 0);
    drain("post_rst_drain");
    check("post_rst_windows", win_cnt - n0, 25);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
